// File: rtl/sar_ctrl_param_if.sv
// Signal bundle between the SAR controller and its environment (analog core side and readout side).
// The slave modport is the controller itself; master is whatever drives enable/start/mode and the comparator.
interface sar_ctrl_param_if #(
    parameter int NBITS = 10
);
    logic             enable;
    logic             start;
    logic             mode;
    logic             comp_p;
    logic             comp_n;
    logic             clks;
    logic             clksb;
    logic             busy;
    logic             eoc;
    logic             err;
    logic [NBITS-1:0] cf;
    logic [NBITS-1:0] dout;
    logic [NBITS-1:0] cdac_p;
    logic [NBITS-1:0] cdac_n;

    modport master (
        output enable, start, mode, comp_p, comp_n,
        input  clks, clksb, busy, eoc, err, cf, dout, cdac_p, cdac_n
    );

    modport slave (
        input  enable, start, mode, comp_p, comp_n,
        output clks, clksb, busy, eoc, err, cf, dout, cdac_p, cdac_n
    );
endinterface

// File: rtl/sar_ctrl_param.sv
// Parametrised N-bit successive-approximation controller for a differential CDAC/comparator front end.
// Optional macro SAR_TIMEOUT_EN: an undecided comparator held TIMEOUT_CYC cycles forces the bit to 0 and sets err.
module sar_ctrl_param #(
    parameter int NBITS       = 10,
    parameter int SAMPLE_CYC  = 2,
    parameter int TIMEOUT_CYC = 8
) (
    input logic             clk,
    input logic             rst_n,
    sar_ctrl_param_if.slave bus
);
    // state    | meaning
    // S_IDLE   | sampling switch open, waiting for enable & (start | mode)
    // S_SAMPLE | sampling switch closed for SAMPLE_CYC cycles
    // S_CONV   | one bit resolved per decided comparator cycle, MSB first
    // S_DONE   | result published to dout, single-cycle eoc

    localparam int             IW       = $clog2(NBITS);
    localparam logic [IW-1:0]  IDX_MSB  = IW'(NBITS - 1);
    localparam logic [3:0]     SMP_LOAD = 4'(SAMPLE_CYC - 1);

    typedef enum logic [1:0] {S_IDLE, S_SAMPLE, S_CONV, S_DONE} state_t;

    state_t           state;
    logic [3:0]       smp_cnt;
    logic [IW-1:0]    idx;
    logic [NBITS-1:0] result;
    logic [NBITS-1:0] res_nxt;
    logic             clks;
    logic             clksb;
    logic             busy;
    logic             eoc;
    logic             err;
    logic [NBITS-1:0] cf;
    logic [NBITS-1:0] dout;
    logic [NBITS-1:0] cdac_p;
    logic [NBITS-1:0] cdac_n;
    logic             decided;
    logic             force_zero;

    assign decided = bus.comp_p ^ bus.comp_n;

`ifdef SAR_TIMEOUT_EN
    localparam int            TW      = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TO_LOAD = TW'(TIMEOUT_CYC - 1);
    logic [TW-1:0] to_cnt;

    assign force_zero = !decided && (to_cnt == '0);
`else
    // No comparator watchdog in this build: never force a bit.
    assign force_zero = (TIMEOUT_CYC < 0);
`endif

    // A forced bit resolves to 0, so one expression covers both a real decision and a timeout.
    always_comb begin
        res_nxt      = result;
        res_nxt[idx] = bus.comp_p & decided;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            smp_cnt <= '0;
            idx     <= '0;
            result  <= '0;
            clks    <= 1'b0;
            clksb   <= 1'b1;
            busy    <= 1'b0;
            eoc     <= 1'b0;
            err     <= 1'b0;
            cf      <= '0;
            dout    <= '0;
            cdac_p  <= '0;
            cdac_n  <= '0;
`ifdef SAR_TIMEOUT_EN
            to_cnt  <= '0;
`endif
        end else if (!bus.enable) begin
            state  <= S_IDLE;
            clks   <= 1'b0;
            clksb  <= 1'b1;
            busy   <= 1'b0;
            eoc    <= 1'b0;
            err    <= 1'b0;
            cf     <= '0;
            cdac_p <= '0;
            cdac_n <= '0;
        end else begin
            eoc <= 1'b0;
            case (state)
                S_IDLE: begin
                    clks   <= 1'b0;
                    clksb  <= 1'b1;
                    busy   <= 1'b0;
                    cf     <= '0;
                    cdac_p <= '0;
                    cdac_n <= '0;
                    if (bus.start || bus.mode) begin
                        state   <= S_SAMPLE;
                        clks    <= 1'b1;
                        clksb   <= 1'b0;
                        busy    <= 1'b1;
                        smp_cnt <= SMP_LOAD;
                        result  <= '0;
                    end
                end
                S_SAMPLE: begin
                    if (smp_cnt == '0) begin
                        state <= S_CONV;
                        clks  <= 1'b0;
                        clksb <= 1'b1;
                        idx   <= IDX_MSB;
`ifdef SAR_TIMEOUT_EN
                        to_cnt <= TO_LOAD;
`endif
                    end else begin
                        smp_cnt <= smp_cnt - 4'd1;
                    end
                end
                S_CONV: begin
                    if (decided || force_zero) begin
                        result      <= res_nxt;
                        cdac_p[idx] <= res_nxt[idx];
                        cdac_n[idx] <= !res_nxt[idx];
                        cf[idx]     <= 1'b1;
                        err         <= err | force_zero;
                        if (idx == '0) begin
                            state <= S_DONE;
                            eoc   <= 1'b1;
                            dout  <= res_nxt;
                        end else begin
                            idx <= idx - 1'b1;
                        end
                    end
`ifdef SAR_TIMEOUT_EN
                    if (decided || force_zero) begin
                        to_cnt <= TO_LOAD;
                    end else begin
                        to_cnt <= to_cnt - 1'b1;
                    end
`endif
                end
                S_DONE: begin
                    cf     <= '0;
                    cdac_p <= '0;
                    cdac_n <= '0;
                    if (bus.mode) begin
                        state   <= S_SAMPLE;
                        clks    <= 1'b1;
                        clksb   <= 1'b0;
                        busy    <= 1'b1;
                        smp_cnt <= SMP_LOAD;
                        result  <= '0;
                    end else begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.clks   = clks;
    assign bus.clksb  = clksb;
    assign bus.busy   = busy;
    assign bus.eoc    = eoc;
    assign bus.err    = err;
    assign bus.cf     = cf;
    assign bus.dout   = dout;
    assign bus.cdac_p = cdac_p;
    assign bus.cdac_n = cdac_n;
endmodule

// File: tb/tb_sar_ctrl_param.sv
// Self-checking bench for sar_ctrl_param: transaction-level SAR model compared every cycle,
// plus literal latency/result checks for the directed scenarios and a randomized run.
module tb_sar_ctrl_param;
    localparam int NB = 10;
    localparam int SC = 2;
    localparam int TO = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    sar_ctrl_param_if #(.NBITS(NB)) bus ();

    sar_ctrl_param #(.NBITS(NB), .SAMPLE_CYC(SC), .TIMEOUT_CYC(TO)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Model: phase of the conversion, how many bits are resolved, and the value accumulated MSB-first.
    typedef enum {P_IDLE, P_SAMPLE, P_CONV, P_DONE} phase_t;
    phase_t ph;
    int     smp_n;
    int     nbits_done;
    int     acc;
    int     und;
    int     m_dout;
    bit     m_err;

    bit auto_comp;
    int tgt;
    int stall_bit;
    int stall_left;
    int eoc_cnt;
    int last_eoc;

    function automatic void chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    task automatic m_reset();
        ph         = P_IDLE;
        smp_n      = 0;
        nbits_done = 0;
        acc        = 0;
        und        = 0;
        m_dout     = 0;
        m_err      = 1'b0;
    endtask

    task automatic m_step();
        if (!bus.enable) begin
            ph    = P_IDLE;
            m_err = 1'b0;
            return;
        end
        case (ph)
            P_IDLE: if (bus.start || bus.mode) begin ph = P_SAMPLE; smp_n = 0; end
            P_SAMPLE: begin
                smp_n++;
                if (smp_n == SC) begin ph = P_CONV; nbits_done = 0; acc = 0; und = 0; end
            end
            P_CONV: begin
                if (bus.comp_p != bus.comp_n) begin
                    acc = acc * 2 + int'(bus.comp_p);
                    nbits_done++;
                    und = 0;
                end else begin
                    und++;
`ifdef SAR_TIMEOUT_EN
                    if (und == TO) begin acc = acc * 2; nbits_done++; und = 0; m_err = 1'b1; end
`endif
                end
                if (nbits_done == NB) begin ph = P_DONE; m_dout = acc; end
            end
            P_DONE: if (bus.mode) begin ph = P_SAMPLE; smp_n = 0; end else ph = P_IDLE;
            default: ph = P_IDLE;
        endcase
    endtask

    task automatic check_all();
        int cfm, cpm, cnm;
        bit conv;
        conv = (ph == P_CONV) || (ph == P_DONE);
        cfm  = conv ? (((1 << nbits_done) - 1) << (NB - nbits_done)) : 0;
        cpm  = conv ? (acc << (NB - nbits_done)) : 0;
        cnm  = cfm & ~cpm;
        chk("clks",   int'(bus.clks),  int'(ph == P_SAMPLE));
        chk("clksb",  int'(bus.clksb), int'(ph != P_SAMPLE));
        chk("busy",   int'(bus.busy),  int'(ph != P_IDLE));
        chk("eoc",    int'(bus.eoc),   int'(ph == P_DONE));
        chk("err",    int'(bus.err),   int'(m_err));
        chk("cf",     int'(bus.cf),     cfm);
        chk("cdac_p", int'(bus.cdac_p), cpm);
        chk("cdac_n", int'(bus.cdac_n), cnm);
        chk("dout",   int'(bus.dout),   m_dout);
    endtask

    task automatic set_comp();
        int b;
        if (ph == P_CONV) begin
            b = NB - 1 - nbits_done;
            if (b == stall_bit && stall_left > 0) begin
                bus.comp_p = 1'b1;
                bus.comp_n = 1'b1;
                stall_left--;
            end else begin
                bus.comp_p = tgt[b];
                bus.comp_n = !tgt[b];
            end
        end else begin
            bus.comp_p = 1'b0;
            bus.comp_n = 1'b0;
        end
    endtask

    task automatic cyc1();
        if (auto_comp) set_comp();
        @(posedge clk);
        m_step();
        @(negedge clk);
        check_all();
        cyc++;
        if (bus.eoc) begin eoc_cnt++; last_eoc = cyc; end
    endtask

    task automatic wait_eoc(input int budget, input string nm);
        int n0;
        n0 = eoc_cnt;
        for (int k = 0; k < budget && eoc_cnt == n0; k++) cyc1();
        if (eoc_cnt == n0) chk({nm, "_eoc_timeout"}, 0, 1);
    endtask

    initial begin
        int t0, first_clks, last_clks, e1, e2, e3, r;
        bus.enable = 1'b0; bus.start = 1'b0; bus.mode = 1'b0;
        bus.comp_p = 1'b0; bus.comp_n = 1'b0;
        auto_comp = 1'b1; tgt = 0; stall_bit = -1; stall_left = 0;
        eoc_cnt = 0; last_eoc = -1;
        m_reset();

        @(negedge clk);
        chk("rst_clks", int'(bus.clks), 0);
        chk("rst_clksb", int'(bus.clksb), 1);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_dout", int'(bus.dout), 0);
        rst_n = 1'b1;
        bus.enable = 1'b1;
        repeat (3) cyc1();

        // Single shot, pattern 1011001110, one decision per cycle.
        tgt = 10'b1011001110;
        first_clks = -1; last_clks = -1; last_eoc = -1; eoc_cnt = 0;
        t0 = cyc; bus.start = 1'b1; cyc1(); bus.start = 1'b0;
        if (bus.clks) begin first_clks = cyc - t0; last_clks = cyc - t0; end
        for (int k = 0; k < 40 && eoc_cnt == 0; k++) begin
            cyc1();
            if (bus.clks) begin if (first_clks < 0) first_clks = cyc - t0; last_clks = cyc - t0; end
        end
        chk("ss_clks_first", first_clks, 1);
        chk("ss_clks_last", last_clks, 2);
        chk("ss_eoc_cycle", last_eoc - t0, 13);
        chk("ss_dout", int'(bus.dout), 10'b1011001110);
        chk("ss_cdac_p", int'(bus.cdac_p), 10'b1011001110);
        chk("ss_cdac_n", int'(bus.cdac_n), 10'b0100110001);
        chk("ss_cf", int'(bus.cf), 10'h3FF);
        cyc1();
        chk("ss_busy_after", int'(bus.busy), 0);

        // START while busy must not queue a second conversion.
        tgt = 10'b0011110000; eoc_cnt = 0;
        bus.start = 1'b1; cyc1(); bus.start = 1'b0;
        repeat (5) cyc1();
        bus.start = 1'b1; cyc1(); bus.start = 1'b0;
        repeat (30) cyc1();
        chk("busy_start_eocs", eoc_cnt, 1);
        chk("busy_start_dout", int'(bus.dout), 10'b0011110000);

        // Stall 3 cycles on bit 5.
        tgt = 10'b0110100101; stall_bit = 5; stall_left = 3; last_eoc = -1; eoc_cnt = 0;
        t0 = cyc; bus.start = 1'b1; cyc1(); bus.start = 1'b0;
        wait_eoc(40, "stall");
        chk("stall_eoc_cycle", last_eoc - t0, 16);
        chk("stall_dout", int'(bus.dout), 10'b0110100101);
        stall_bit = -1;
        repeat (2) cyc1();

        // Continuous mode: EOC every SAMPLE_CYC+NBITS+1 cycles.
        tgt = 10'b1100110011; eoc_cnt = 0;
        t0 = cyc; bus.mode = 1'b1; cyc1();
        wait_eoc(40, "cont1"); e1 = last_eoc;
        bus.start = 1'b1; cyc1(); bus.start = 1'b0;
        wait_eoc(40, "cont2"); e2 = last_eoc;
        wait_eoc(40, "cont3"); e3 = last_eoc;
        chk("cont_first", e1 - t0, 13);
        chk("cont_period1", e2 - e1, 13);
        chk("cont_period2", e3 - e2, 13);
        repeat (4) cyc1();
        bus.mode = 1'b0;
        wait_eoc(40, "cont_last");
        cyc1();
        chk("cont_stop_busy", int'(bus.busy), 0);
        eoc_cnt = 0;
        repeat (20) cyc1();
        chk("cont_stop_eocs", eoc_cnt, 0);

        // Abort at bit 3 (six bits resolved) by dropping enable.
        tgt = 10'b1111111111; eoc_cnt = 0;
        bus.start = 1'b1; cyc1(); bus.start = 1'b0;
        for (int k = 0; k < 40 && !(ph == P_CONV && nbits_done == 6); k++) cyc1();
        chk("abort_reached", nbits_done, 6);
        bus.enable = 1'b0; cyc1(); bus.enable = 1'b1;
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_cf", int'(bus.cf), 0);
        chk("abort_cdac_p", int'(bus.cdac_p), 0);
        chk("abort_dout", int'(bus.dout), 10'b1100110011);
        repeat (20) cyc1();
        chk("abort_eocs", eoc_cnt, 0);

        // Asynchronous reset in the middle of CONV.
        tgt = 10'b1010101010;
        bus.start = 1'b1; cyc1(); bus.start = 1'b0;
        for (int k = 0; k < 40 && !(ph == P_CONV && nbits_done == 3); k++) cyc1();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", int'(bus.busy), 0);
        chk("arst_clksb", int'(bus.clksb), 1);
        chk("arst_cf", int'(bus.cf), 0);
        chk("arst_cdac_p", int'(bus.cdac_p), 0);
        chk("arst_cdac_n", int'(bus.cdac_n), 0);
        chk("arst_dout", int'(bus.dout), 0);
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) cyc1();

`ifdef SAR_TIMEOUT_EN
        // Comparator stuck at bit 7: forced to 0 after TO cycles, err sticky until enable low.
        tgt = 10'b1111111111; stall_bit = 7; stall_left = 1000; last_eoc = -1;
        t0 = cyc; bus.start = 1'b1; cyc1(); bus.start = 1'b0;
        wait_eoc(60, "to");
        chk("to_eoc_cycle", last_eoc - t0, 13 + TO - 1);
        chk("to_dout", int'(bus.dout), 10'b1101111111);
        chk("to_err", int'(bus.err), 1);
        repeat (10) cyc1();
        chk("to_err_sticky", int'(bus.err), 1);
        bus.enable = 1'b0; cyc1(); bus.enable = 1'b1;
        chk("to_err_clear", int'(bus.err), 0);
        stall_bit = -1;
`endif

        // Randomized traffic against the model.
        auto_comp = 1'b0;
        for (int k = 0; k < 1500; k++) begin
            bus.enable = ($urandom_range(0, 39) != 0);
            bus.start  = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 29) == 0) bus.mode = !bus.mode;
            r = int'($urandom_range(0, 4));
            bus.comp_p = $urandom_range(0, 1) == 1;
            bus.comp_n = (r == 0) ? bus.comp_p : !bus.comp_p;
            cyc1();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got 0 expected 1");
        $fatal(1, "bench time limit");
    end
endmodule

// File: doc/sar_ctrl_param.md
Name: sar_ctrl_param

Overview:
- Parametrised N-bit successive-approximation controller for the differential CDAC/comparator ADC front end; next generation of the fixed 10-bit SAR controller.
- Adds configurable resolution and sample length, single-shot/continuous modes, and a START handshake.
- Waits on an undecided comparator (COMP_P == COMP_N) instead of assuming a fixed decision time.
- Sits between the analog core (CDAC switches, comparator, sampling switch) and the digital readout.

Parameters:
- NBITS, 10, conversion resolution; legal range 4..16.
- SAMPLE_CYC, 2, CLK cycles the sampling switch is held closed; legal range 1..15.
- TIMEOUT_CYC, 8, undecided-comparator cycles tolerated per bit; used only with SAR_TIMEOUT_EN.

Ports:
- CLK  in  1  system clock; all state updates on its rising edge.
- RST_N  in  1  asynchronous active-low reset.
- ENABLE  in  1  block enable; low forces IDLE.
- START  in  1  single-shot conversion request; sampled in IDLE only.
- MODE  in  1  0 = single-shot, 1 = continuous while ENABLE is high.
- COMP_P  in  1  comparator positive output.
- COMP_N  in  1  comparator negative output.
- CLKS  out  1  sampling switch control, high in SAMPLE.
- CLKSB  out  1  complement of CLKS.
- BUSY  out  1  high in SAMPLE, CONV and DONE.
- EOC  out  1  one-cycle end-of-conversion pulse.
- CF  out  NBITS  bit-decided flags; CF[NBITS-1] is the MSB.
- DOUT  out  NBITS  last completed result; MSB at [NBITS-1].
- CDAC_P  out  NBITS  P-side capacitor switch controls.
- CDAC_N  out  NBITS  N-side capacitor switch controls.
- ERR  out  1  sticky comparator-timeout flag.

Behaviour:
- Reset (RST_N low, asynchronous):
  - State IDLE.
  - CLKS=0, CLKSB=1, BUSY=0, EOC=0, ERR=0.
  - CF, DOUT, CDAC_P and CDAC_N all zero.
- All outputs are registered.
- FSM states: IDLE, SAMPLE, CONV, DONE.
- IDLE:
  - CLKS=0, CLKSB=1; CF, CDAC_P and CDAC_N cleared.
  - Go to SAMPLE if ENABLE and (START or MODE); otherwise stay.
- SAMPLE:
  - CLKS=1, CLKSB=0, CDAC_P=CDAC_N=0, CF=0.
  - Lasts exactly SAMPLE_CYC cycles, then go to CONV with bit index i=NBITS-1.
- CONV:
  - CLKS=0.
  - Each cycle, if COMP_P != COMP_N:
    - result[i] <= COMP_P.
    - CDAC_P[i] <= COMP_P; CDAC_N[i] <= COMP_N.
    - CF[i] <= 1.
    - Decrement i. After i=0 is decided, go to DONE.
  - If COMP_P == COMP_N: hold, no register change.
- DONE (one cycle):
  - DOUT <= result; EOC=1 for this cycle only.
  - Next state is SAMPLE if ENABLE and MODE, else IDLE.
- Latency with the comparator always decided: START sampled at edge t0 gives SAMPLE in cycles t0+1..t0+SAMPLE_CYC, CONV for NBITS cycles, EOC high in cycle t0+SAMPLE_CYC+NBITS+1.
- Continuous mode: back-to-back conversions, one every SAMPLE_CYC+NBITS+1 cycles.
- START while BUSY is ignored, not queued.
- ENABLE low in any state: next edge goes to IDLE.
  - Partial conversion discarded; CF and CDAC cleared.
  - DOUT retains its last completed value; no EOC.
- MODE changes take effect only at the DONE decision.
- DOUT changes only in DONE; it is stable between EOC pulses.

Optional Feature:
- Macro: SAR_TIMEOUT_EN.
- Defined:
  - Per-bit counter counts consecutive undecided CONV cycles.
  - On reaching TIMEOUT_CYC: bit i forced to 0 (CDAC_N[i]=1, CDAC_P[i]=0, CF[i]=1), ERR set.
  - Conversion then continues with the next bit.
  - ERR is cleared only by reset or by ENABLE low.
- Not defined: no counter; CONV waits indefinitely; ERR tied 0.

Test Plan:
- Reset: RST_N low mid-CONV -> all outputs at reset values immediately, without waiting for a CLK edge.
- Single-shot, NBITS=10, SAMPLE_CYC=2:
  - Stimulus: START pulse at t0; comparator returns bit pattern 1011001110 MSB-first, one decision per cycle.
  - Required: CLKS high for cycles t0+1..t0+2; CF fills from MSB; EOC high in cycle t0+13 only; DOUT=10'b1011001110; CDAC_P=DOUT, CDAC_N=~DOUT; BUSY low from t0+14.
- Stall: COMP_P=COMP_N=1 for 3 cycles during bit 5 -> EOC delayed by exactly 3 cycles; DOUT correct.
- Continuous: MODE=1, ENABLE=1 -> EOC pulses every 13 cycles. Drop MODE -> returns to IDLE after the current DONE. START while BUSY -> no extra conversion.
- Abort: ENABLE low at CONV bit 3 -> IDLE next cycle; CF=0, CDAC=0; DOUT holds its previous value; no EOC.
- SAR_TIMEOUT_EN, TIMEOUT_CYC=8: comparator stuck equal at bit 7 -> after 8 cycles bit 7 = 0 and ERR=1; conversion completes; ERR stays 1 until ENABLE low.
